// File: rtl/block_sync_pkg.sv
// Shared types and helpers for the 64b/66b block-lock receive path.
// Sync header encodings, lane state encoding and header validity.
package block_sync_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_TEST,
    ST_LOCKED,
    ST_SLIP_WAIT
  } lane_st_e;

  function automatic logic head_ok(input logic [1:0] h);
    return (h == SYNC_DATA) || (h == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_rx_lane.sv
// Single-lane sync-header lock FSM with lock, window, bad-header
// and slip hold-off counters.
module block_sync_rx_lane
  import block_sync_pkg::*;
#(
  parameter int HEAD_W    = 2,
  parameter int LOCK_CNT  = 64,
  parameter int WIN_CNT   = 1024,
  parameter int BAD_CNT   = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              signal_v_i,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  output logic              slip_v_o,
  output logic              lock_v_o
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = $clog2(WIN_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_CNT + 1);
  localparam int WAIT_W =
    (SLIP_WAIT < 1) ? 1 : $clog2(SLIP_WAIT + 1);
  localparam lane_st_e SLIP_NEXT =
    (SLIP_WAIT == 0) ? ST_TEST : ST_SLIP_WAIT;

  lane_st_e          state_q, state_d;
  logic [GOOD_W-1:0] good_q, good_d, good_inc;
  logic [WIN_W-1:0]  win_q, win_d, win_inc;
  logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lock_q, lock_d;
  logic              slip_q, slip_d;
  logic              hv;

  assign hv       = head_ok(head_i);
  assign good_inc = good_q + GOOD_W'(1);
  assign win_inc  = win_q + WIN_W'(1);
  assign bad_inc  = bad_q + BAD_W'(!hv);

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    win_d   = win_q;
    bad_d   = bad_q;
    wait_d  = wait_q;
    lock_d  = lock_q;
    slip_d  = 1'b0;
    if (!signal_v_i) begin
      // signal loss beats everything, including a pending slip
      state_d = ST_INIT;
      good_d  = '0;
      win_d   = '0;
      bad_d   = '0;
      wait_d  = '0;
      lock_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          state_d = ST_TEST;
          good_d  = '0;
        end
        ST_TEST: begin
          if (valid_i) begin
            if (hv) begin
              good_d = good_inc;
              if (good_inc == GOOD_W'(LOCK_CNT)) begin
                lock_d  = 1'b1;
                win_d   = '0;
                bad_d   = '0;
                state_d = ST_LOCKED;
              end
            end else begin
              slip_d  = 1'b1;
              good_d  = '0;
              wait_d  = '0;
              state_d = SLIP_NEXT;
            end
          end
        end
        ST_LOCKED: begin
          if (valid_i) begin
            if (bad_inc == BAD_W'(BAD_CNT)) begin
              lock_d  = 1'b0;
              slip_d  = 1'b1;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
              wait_d  = '0;
              state_d = SLIP_NEXT;
            end else if (win_inc == WIN_W'(WIN_CNT)) begin
              win_d = '0;
              bad_d = '0;
            end else begin
              win_d = win_inc;
              bad_d = bad_inc;
            end
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_q == WAIT_W'(SLIP_WAIT - 1)) begin
            wait_d  = '0;
            good_d  = '0;
            state_d = ST_TEST;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_INIT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      wait_q  <= '0;
      lock_q  <= 1'b0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      wait_q  <= wait_d;
      lock_q  <= lock_d;
      slip_q  <= slip_d;
    end
  end

  assign slip_v_o = slip_q;
  assign lock_v_o = lock_q;

endmodule

// File: rtl/block_sync_rx_multi.sv
// Multi-lane 64b/66b block-lock engine: independent lane FSMs
// plus a registered all-lanes-locked flag for deskew.
module block_sync_rx_multi
  import block_sync_pkg::*;
#(
  parameter int LANE_CNT  = 4,
  parameter int HEAD_W    = 2,
  parameter int LOCK_CNT  = 64,
  parameter int WIN_CNT   = 1024,
  parameter int BAD_CNT   = 16,
  parameter int SLIP_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [LANE_CNT-1:0]        signal_v_i,
  input  logic [LANE_CNT-1:0]        valid_i,
  input  logic [LANE_CNT*HEAD_W-1:0] head_i,
  output logic [LANE_CNT-1:0]        slip_v_o,
  output logic [LANE_CNT-1:0]        lock_v_o,
  output logic                       all_lock_v_o
);

  logic all_lock_q;

  for (genvar n = 0; n < LANE_CNT; n++) begin : g_lane
    block_sync_rx_lane #(
      .HEAD_W    (HEAD_W),
      .LOCK_CNT  (LOCK_CNT),
      .WIN_CNT   (WIN_CNT),
      .BAD_CNT   (BAD_CNT),
      .SLIP_WAIT (SLIP_WAIT)
    ) u_lane (
      .clk        (clk),
      .nreset     (nreset),
      .signal_v_i (signal_v_i[n]),
      .valid_i    (valid_i[n]),
      .head_i     (head_i[n*HEAD_W +: HEAD_W]),
      .slip_v_o   (slip_v_o[n]),
      .lock_v_o   (lock_v_o[n])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) all_lock_q <= 1'b0;
    else         all_lock_q <= &lock_v_o;
  end

  assign all_lock_v_o = all_lock_q;

endmodule

// File: tb/tb_block_sync_rx_multi.sv
// Directed bench for block_sync_rx_multi with a cycle model feeding
// an expected-output queue.
module tb_block_sync_rx_multi;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [3:0] sig = '0;
  logic [3:0] vld = '0;
  logic [7:0] hd = '0;
  logic [3:0] slip_v_o;
  logic [3:0] lock_v_o;
  logic       all_lock_v_o;

  always #5 clk = ~clk;

  block_sync_rx_multi dut (
    .clk          (clk),
    .nreset       (nreset),
    .signal_v_i   (sig),
    .valid_i      (vld),
    .head_i       (hd),
    .slip_v_o     (slip_v_o),
    .lock_v_o     (lock_v_o),
    .all_lock_v_o (all_lock_v_o)
  );

  typedef struct packed {
    logic [3:0] slip;
    logic [3:0] lock;
    logic       all;
  } exp_t;

  exp_t sb_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  int m_st[4];
  int m_good[4];
  int m_win[4];
  int m_bad[4];
  int m_wait[4];
  logic [3:0] m_lock;
  logic [3:0] m_slip;
  logic [3:0] slip_or;
  logic [3:0] lock_lost;

  function automatic logic hok(input logic [1:0] h);
    return (h == 2'b01) || (h == 2'b10);
  endfunction

  function automatic logic [7:0] good_hd();
    logic [7:0] r;
    for (int i = 0; i < 4; i++)
      r[i*2 +: 2] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin
      m_st[l] = 0; m_good[l] = 0; m_win[l] = 0;
      m_bad[l] = 0; m_wait[l] = 0;
    end
    m_lock = '0;
    m_slip = '0;
  endtask

  // states: 0 init, 1 test, 2 locked, 3 hold-off (counts down)
  task automatic model_step();
    logic [1:0] h;
    for (int l = 0; l < 4; l++) begin
      h = hd[l*2 +: 2];
      m_slip[l] = 1'b0;
      if (!sig[l]) begin
        m_st[l] = 0; m_lock[l] = 1'b0;
        m_good[l] = 0; m_win[l] = 0; m_bad[l] = 0; m_wait[l] = 0;
      end else begin
        case (m_st[l])
          0: begin m_st[l] = 1; m_good[l] = 0; end
          1: if (vld[l]) begin
            if (hok(h)) begin
              m_good[l]++;
              if (m_good[l] == 64) begin
                m_lock[l] = 1'b1; m_win[l] = 0; m_bad[l] = 0; m_st[l] = 2;
              end
            end else begin
              m_slip[l] = 1'b1; m_good[l] = 0; m_st[l] = 3; m_wait[l] = 4;
            end
          end
          2: if (vld[l]) begin
            m_win[l]++;
            if (!hok(h)) m_bad[l]++;
            if (m_bad[l] == 16) begin
              m_lock[l] = 1'b0; m_slip[l] = 1'b1; m_good[l] = 0;
              m_win[l] = 0; m_bad[l] = 0; m_st[l] = 3; m_wait[l] = 4;
            end else if (m_win[l] == 1024) begin
              m_win[l] = 0; m_bad[l] = 0;
            end
          end
          3: begin
            m_wait[l]--;
            if (m_wait[l] == 0) begin m_st[l] = 1; m_good[l] = 0; end
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic step(input logic [3:0] s, input logic [3:0] v,
                      input logic [7:0] h);
    exp_t e;
    @(negedge clk);
    sig = s; vld = v; hd = h;
    e.all = &m_lock;
    model_step();
    e.slip = m_slip;
    e.lock = m_lock;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    slip_or   |= slip_v_o;
    lock_lost |= ~lock_v_o;
    e = sb_q.pop_front();
    chk("sb", {slip_v_o, lock_v_o, all_lock_v_o}, e);
  endtask

  initial begin
    logic [3:0] v;
    logic [7:0] h;
    int nv;
    int last;
    int pulses;

    model_reset();
    slip_or = '0;
    lock_lost = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_slip", slip_v_o, 0);
    chk("rst_lock", lock_v_o, 0);
    chk("rst_all", all_lock_v_o, 0);
    @(negedge clk);
    nreset = 1'b1;

    // acquire with random valid gaps
    step(4'hF, 4'h0, good_hd());
    nv = 0;
    while (nv < 64) begin
      v = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF;
      step(4'hF, v, good_hd());
      if (v != 0) begin
        nv++;
        if (nv == 63) chk("acq_63", lock_v_o, 0);
      end
    end
    chk("acq_lock", lock_v_o, 4'hF);
    chk("acq_all_pre", all_lock_v_o, 0);
    step(4'hF, 4'h0, good_hd());
    chk("acq_all", all_lock_v_o, 1);
    chk("acq_noslip", slip_or, 0);

    // lose lock on lane 2
    for (int i = 0; i < 150; i++) begin
      h = good_hd();
      if (i % 10 == 0) h[5:4] = 2'b00;
      step(4'hF, 4'hF, h);
    end
    chk("ll15_lock", lock_v_o, 4'hF);
    h = good_hd();
    h[5:4] = 2'b11;
    step(4'hF, 4'hF, h);
    chk("ll16_lock", lock_v_o, 4'b1011);
    chk("ll16_slip", slip_v_o, 4'b0100);
    step(4'hF, 4'hF, good_hd());
    chk("ll_all", all_lock_v_o, 0);
    chk("ll_slip1", slip_v_o, 0);
    repeat (80) step(4'hF, 4'hF, good_hd());
    chk("ll_relock", lock_v_o, 4'hF);

    // align lane 2 to a window start, then 15 bad per window
    for (int i = 0; i < 1100 && m_win[2] != 0; i++)
      step(4'hF, 4'hF, good_hd());
    lock_lost = '0;
    for (int i = 0; i < 2048; i++) begin
      h = good_hd();
      if ((i % 1024) < 960 && (i % 64) == 0)
        h[5:4] = (i % 128 == 0) ? 2'b00 : 2'b11;
      step(4'hF, 4'hF, h);
    end
    chk("win_lost", lock_lost, 0);
    chk("win_lock", lock_v_o, 4'hF);

    // continuous invalid on lane 3
    pulses = 0;
    last = 0;
    for (int i = 0; i < 80; i++) begin
      h = good_hd();
      h[7:6] = 2'b00;
      step(4'hF, 4'hF, h);
      if (slip_v_o[3]) begin
        if (pulses > 0) chk("slip_gap", i - last, 5);
        pulses++;
        last = i;
      end
    end
    chk("slip_cnt", pulses >= 9, 1);
    chk("slip_nolock", lock_v_o[3], 0);
    repeat (80) step(4'hF, 4'hF, good_hd());
    chk("slip_relock", lock_v_o, 4'hF);

    // valid low with arbitrary headers
    slip_or = '0;
    lock_lost = '0;
    repeat (10) step(4'hF, 4'h0, 8'($urandom()));
    chk("gap_lost", lock_lost, 0);
    chk("gap_slip", slip_or, 0);

    // signal loss and recovery
    slip_or = '0;
    step(4'h0, 4'hF, good_hd());
    chk("sl_lock", lock_v_o, 0);
    repeat (63) step(4'h0, 4'hF, good_hd());
    chk("sl_slip", slip_or, 0);
    chk("sl_all", all_lock_v_o, 0);
    step(4'hF, 4'hF, good_hd());
    repeat (63) step(4'hF, 4'hF, good_hd());
    chk("sl_63", lock_v_o, 0);
    step(4'hF, 4'hF, good_hd());
    chk("sl_relock", lock_v_o, 4'hF);
    step(4'hF, 4'hF, good_hd());
    chk("sl_all1", all_lock_v_o, 1);

    // asynchronous reset mid-operation
    @(posedge clk);
    #3;
    nreset = 1'b0;
    #1;
    chk("ar_lock", lock_v_o, 0);
    chk("ar_all", all_lock_v_o, 0);
    chk("ar_slip", slip_v_o, 0);
    model_reset();
    @(negedge clk);
    nreset = 1'b1;
    step(4'hF, 4'hF, good_hd());
    chk("ar_after", lock_v_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
